// File: rtl/mult_all_pkg.sv
// mult_all_pkg
// Shared constants and types for the mult_all multiplier bank.
//   BIAS / EXP_MAX   : fp32 exponent bias and the all-ones exponent value
//   DRUM_K           : width of the leading-one slice used by the DRUM path
//   FOIL_SPLIT       : split point of the 24-bit significand for the FOIL path
//   PATH_*           : index of each datapath in the per-path arrays
//   path_out_t       : registered result plus overflow/underflow of one path
package mult_all_pkg;

    localparam int BIAS       = 127;
    localparam int EXP_MAX    = 255;
    localparam int DRUM_K     = 6;
    localparam int FOIL_SPLIT = 12;

    localparam int SIG_W  = 24;
    localparam int PROD_W = 2 * SIG_W;

    localparam int NUM_PATHS     = 4;
    localparam int PATH_EXACT    = 0;
    localparam int PATH_MITCHELL = 1;
    localparam int PATH_DRUM     = 2;
    localparam int PATH_FOIL     = 3;

    typedef struct packed {
        logic [31:0] result;
        logic        overflow;
        logic        underflow;
    } path_out_t;

endpackage

// File: rtl/fp_mul_pack.sv
// fp_mul_pack
// Normalizes one significand product and packs it into an fp32 word with
// truncation rounding, applying the special-case priority
// (exception > zero operand > overflow > underflow > normal).
// Ports:
//   sign        : product sign
//   exp_sum     : raw sum of the two biased exponents (9 bits)
//   prod        : 48-bit significand product (ignored when direct_en = 1)
//   direct_en   : use direct_mant/direct_inc instead of normalizing prod
//   direct_mant : pre-normalized 23-bit mantissa (Mitchell path)
//   direct_inc  : exponent increment matching direct_mant
//   exception   : an operand is Inf/NaN
//   zero_in     : an operand has a zero exponent
//   result      : packed fp32 result
//   overflow    : biased exponent reached EXP_MAX or above
//   underflow   : biased exponent fell to zero or below
module fp_mul_pack
    import mult_all_pkg::*;
(
    input  logic              sign,
    input  logic [8:0]        exp_sum,
    input  logic [PROD_W-1:0] prod,
    input  logic              direct_en,
    input  logic [22:0]       direct_mant,
    input  logic              direct_inc,
    input  logic              exception,
    input  logic              zero_in,
    output logic [31:0]       result,
    output logic              overflow,
    output logic              underflow
);

    localparam logic signed [9:0] EXP_MAX_S = 10'(EXP_MAX);

    logic [22:0]       mant;
    logic              inc;
    logic signed [9:0] exp_full;

    // Bits below the truncation point never reach the result.
    logic [22:0] unused_prod_low;
    assign unused_prod_low = prod[22:0];

    // A product of two values in [1,2) lies in [1,4); bit 47 tells which half.
    always_comb begin
        mant = 23'h0;
        inc  = 1'b0;
        if (direct_en) begin
            mant = direct_mant;
            inc  = direct_inc;
        end else if (prod[PROD_W-1]) begin
            mant = prod[46:24];
            inc  = 1'b1;
        end else begin
            mant = prod[45:23];
            inc  = 1'b0;
        end
    end

    // Ten signed bits hold the full range -127 .. 384.
    assign exp_full = {1'b0, exp_sum} + 10'(inc) - 10'(BIAS);

    always_comb begin
        result    = {sign, exp_full[7:0], mant};
        overflow  = 1'b0;
        underflow = 1'b0;
        if (exception) begin
            result = {sign, 8'hFF, 23'h0};
        end else if (zero_in) begin
            result = {sign, 31'h0};
        end else if (exp_full >= EXP_MAX_S) begin
            overflow = 1'b1;
            result   = {sign, 8'hFF, 23'h0};
        end else if (exp_full <= 10'sd0) begin
            underflow = 1'b1;
            result    = {sign, 31'h0};
        end
    end

endmodule

// File: rtl/mult_all.sv
// mult_all
// Registered fp32 multiplier bank: one operand pair feeds four datapaths
// (exact, Mitchell, DRUM, FOIL) whose results and flags update together
// one cycle after the operands are sampled.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   a_operand, b_operand           : fp32 operands
//   result / result_approx /
//   result_drum / result_foil      : exact, Mitchell, DRUM and FOIL products
//   Exception                      : an operand is Inf/NaN
//   Overflow*/Underflow*           : per-path range flags
module mult_all
    import mult_all_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a_operand,
    input  logic [31:0] b_operand,
    output logic [31:0] result,
    output logic [31:0] result_approx,
    output logic [31:0] result_drum,
    output logic [31:0] result_foil,
    output logic        Exception,
    output logic        Overflow,
    output logic        Underflow,
    output logic        Overflow_approx,
    output logic        Underflow_approx,
    output logic        Overflow_drum,
    output logic        Underflow_drum,
    output logic        Overflow_foil,
    output logic        Underflow_foil
);

    localparam int FOIL_HI_W = SIG_W - FOIL_SPLIT;

    logic              sign;
    logic [8:0]        exp_sum;
    logic              exception;
    logic              zero_in;
    logic [SIG_W-1:0]  ma;
    logic [SIG_W-1:0]  mb;

    logic [PROD_W-1:0] path_prod [NUM_PATHS];
    logic [31:0]       pack_result [NUM_PATHS];
    logic              pack_ovf [NUM_PATHS];
    logic              pack_unf [NUM_PATHS];

    logic [SIG_W-1:0]    mitch_sum;
    logic [DRUM_K-1:0]   drum_a;
    logic [DRUM_K-1:0]   drum_b;
    logic [2*DRUM_K-1:0] drum_prod;
    logic [FOIL_HI_W-1:0]  foil_ah;
    logic [FOIL_HI_W-1:0]  foil_bh;
    logic [FOIL_SPLIT-1:0] foil_al;
    logic [FOIL_SPLIT-1:0] foil_bl;

    path_out_t path_d [NUM_PATHS];
    path_out_t path_q [NUM_PATHS];
    logic      exception_d;
    logic      exception_q;

    // Fields shared by every datapath.
    assign sign      = a_operand[31] ^ b_operand[31];
    assign exp_sum   = {1'b0, a_operand[30:23]} + {1'b0, b_operand[30:23]};
    assign exception = (&a_operand[30:23]) | (&b_operand[30:23]);
    assign zero_in   = ~(|a_operand[30:23]) | ~(|b_operand[30:23]);
    assign ma        = {1'b1, a_operand[22:0]};
    assign mb        = {1'b1, b_operand[22:0]};

    // Exact significand product.
    assign path_prod[PATH_EXACT] = PROD_W'(ma) * PROD_W'(mb);

    // Mitchell: log-domain add of the fractions. The carry out of x+y is the
    // 2(x+y) case, so the low bits are the mantissa in both cases and the
    // carry is the exponent increment.
    assign mitch_sum = {1'b0, a_operand[22:0]} + {1'b0, b_operand[22:0]};
    assign path_prod[PATH_MITCHELL] = '0;

    // DRUM: leading slice with its LSB forced high to unbias the truncation,
    // product left-aligned into the full product width.
    assign drum_a    = {ma[SIG_W-1 -: DRUM_K-1], 1'b1};
    assign drum_b    = {mb[SIG_W-1 -: DRUM_K-1], 1'b1};
    assign drum_prod = (2*DRUM_K)'(drum_a) * (2*DRUM_K)'(drum_b);
    assign path_prod[PATH_DRUM] = {drum_prod, {(PROD_W-2*DRUM_K){1'b0}}};

    // FOIL: high*high plus both cross terms; the low*low term is dropped.
    assign foil_ah = ma[SIG_W-1:FOIL_SPLIT];
    assign foil_al = ma[FOIL_SPLIT-1:0];
    assign foil_bh = mb[SIG_W-1:FOIL_SPLIT];
    assign foil_bl = mb[FOIL_SPLIT-1:0];
    assign path_prod[PATH_FOIL] =
        ((PROD_W'(foil_ah) * PROD_W'(foil_bh)) << (2*FOIL_SPLIT)) +
        (((PROD_W'(foil_ah) * PROD_W'(foil_bl)) +
          (PROD_W'(foil_al) * PROD_W'(foil_bh))) << FOIL_SPLIT);

    // One packer per path; only the Mitchell path bypasses normalization.
    for (genvar i = 0; i < NUM_PATHS; i++) begin : g_pack
        fp_mul_pack u_pack (
            .sign        (sign),
            .exp_sum     (exp_sum),
            .prod        (path_prod[i]),
            .direct_en   (i == PATH_MITCHELL),
            .direct_mant (mitch_sum[22:0]),
            .direct_inc  (mitch_sum[23]),
            .exception   (exception),
            .zero_in     (zero_in),
            .result      (pack_result[i]),
            .overflow    (pack_ovf[i]),
            .underflow   (pack_unf[i])
        );
    end

    // Next-state values for the output registers.
    always_comb begin
        exception_d = exception;
        for (int i = 0; i < NUM_PATHS; i++) begin
            path_d[i] = '{result: pack_result[i],
                          overflow: pack_ovf[i],
                          underflow: pack_unf[i]};
        end
    end

    // All outputs register together; reset wins over any operand in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            exception_q <= 1'b0;
            for (int i = 0; i < NUM_PATHS; i++) begin
                path_q[i] <= '0;
            end
        end else begin
            exception_q <= exception_d;
            for (int i = 0; i < NUM_PATHS; i++) begin
                path_q[i] <= path_d[i];
            end
        end
    end

    assign result           = path_q[PATH_EXACT].result;
    assign result_approx    = path_q[PATH_MITCHELL].result;
    assign result_drum      = path_q[PATH_DRUM].result;
    assign result_foil      = path_q[PATH_FOIL].result;
    assign Exception        = exception_q;
    assign Overflow         = path_q[PATH_EXACT].overflow;
    assign Underflow        = path_q[PATH_EXACT].underflow;
    assign Overflow_approx  = path_q[PATH_MITCHELL].overflow;
    assign Underflow_approx = path_q[PATH_MITCHELL].underflow;
    assign Overflow_drum    = path_q[PATH_DRUM].overflow;
    assign Underflow_drum   = path_q[PATH_DRUM].underflow;
    assign Overflow_foil    = path_q[PATH_FOIL].overflow;
    assign Underflow_foil   = path_q[PATH_FOIL].underflow;

endmodule

// File: tb/tb_mult_all.sv
// tb_mult_all
// Self-checking bench for mult_all: directed cases with hand-derived
// constants, then random operand pairs compared against an arithmetic
// reference model of the four multipliers.
module tb_mult_all;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a_operand;
    logic [31:0] b_operand;
    logic [31:0] result;
    logic [31:0] result_approx;
    logic [31:0] result_drum;
    logic [31:0] result_foil;
    logic        Exception;
    logic        Overflow;
    logic        Underflow;
    logic        Overflow_approx;
    logic        Underflow_approx;
    logic        Overflow_drum;
    logic        Underflow_drum;
    logic        Overflow_foil;
    logic        Underflow_foil;

    int vectors     = 0;
    int miscompares = 0;

    // Expected values: results per path and flags
    // {Exception, ovf/unf exact, Mitchell, DRUM, FOIL}.
    logic [31:0] expRes [4];
    logic [8:0]  expFlags;
    logic [8:0]  obsFlags;

    assign obsFlags = {Exception, Overflow, Underflow,
                       Overflow_approx, Underflow_approx,
                       Overflow_drum, Underflow_drum,
                       Overflow_foil, Underflow_foil};

    mult_all dut (
        .clk              (clk),
        .rst              (rst),
        .a_operand        (a_operand),
        .b_operand        (b_operand),
        .result           (result),
        .result_approx    (result_approx),
        .result_drum      (result_drum),
        .result_foil      (result_foil),
        .Exception        (Exception),
        .Overflow         (Overflow),
        .Underflow        (Underflow),
        .Overflow_approx  (Overflow_approx),
        .Underflow_approx (Underflow_approx),
        .Overflow_drum    (Overflow_drum),
        .Underflow_drum   (Underflow_drum),
        .Overflow_foil    (Overflow_foil),
        .Underflow_foil   (Underflow_foil)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Turns a real-valued significand product (scaled by 2^46) into an fp32
    // word following the rounding and special-case rules.
    function automatic logic [33:0] packRef(input logic s, input int ea, input int eb,
                                            input longint unsigned p, input bit useDirect,
                                            input int dMant, input int dInc);
        int          mant;
        int          inc;
        int          e;
        logic [31:0] r;
        logic [7:0]  e8;
        if (useDirect) begin
            mant = dMant;
            inc  = dInc;
        end else if (p >= (64'd1 << 47)) begin
            mant = int'((p >> 24) & 64'h7F_FFFF);
            inc  = 1;
        end else begin
            mant = int'((p >> 23) & 64'h7F_FFFF);
            inc  = 0;
        end
        if (ea == 255 || eb == 255) begin
            r = {s, 8'hFF, 23'h0};
            return {2'b00, r};
        end
        if (ea == 0 || eb == 0) begin
            r = {s, 31'h0};
            return {2'b00, r};
        end
        e = ea + eb - 127 + inc;
        if (e >= 255) begin
            r = {s, 8'hFF, 23'h0};
            return {2'b10, r};
        end
        if (e <= 0) begin
            r = {s, 31'h0};
            return {2'b01, r};
        end
        e8 = e[7:0];
        r  = {s, e8, mant[22:0]};
        return {2'b00, r};
    endfunction

    // Reference model of all four multipliers for one operand pair.
    task automatic computeExpected(input logic [31:0] a, input logic [31:0] b);
        logic              s;
        int                ea, eb, x, y, sum;
        longint unsigned   ma, mb, ta, tb, ah, al, bh, bl, p;
        logic [33:0]       o [4];
        s  = a[31] ^ b[31];
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        x  = int'(a[22:0]);
        y  = int'(b[22:0]);
        ma = 64'(x) + (64'd1 << 23);
        mb = 64'(y) + (64'd1 << 23);

        o[0] = packRef(s, ea, eb, ma * mb, 1'b0, 0, 0);

        // Mitchell: 1+x+y when x+y<1, otherwise 2(x+y) -> mantissa x+y-1.
        sum = x + y;
        if (sum < (1 << 23)) o[1] = packRef(s, ea, eb, 64'd0, 1'b1, sum, 0);
        else                 o[1] = packRef(s, ea, eb, 64'd0, 1'b1, sum - (1 << 23), 1);

        ta   = (ma >> 18) | 64'd1;
        tb   = (mb >> 18) | 64'd1;
        o[2] = packRef(s, ea, eb, (ta * tb) << 36, 1'b0, 0, 0);

        ah   = ma >> 12;
        al   = ma & 64'hFFF;
        bh   = mb >> 12;
        bl   = mb & 64'hFFF;
        p    = ((ah * bh) << 24) + ((ah * bl + al * bh) << 12);
        o[3] = packRef(s, ea, eb, p, 1'b0, 0, 0);

        for (int i = 0; i < 4; i++) expRes[i] = o[i][31:0];
        expFlags = {(ea == 255 || eb == 255), o[0][33:32], o[1][33:32],
                    o[2][33:32], o[3][33:32]};
    endtask

    // Drives one operand pair, lets it register, and leaves the bench on the
    // following falling edge with outputs stable.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
        a_operand = a;
        b_operand = b;
        computeExpected(a, b);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic checkAgainstModel(input string tag);
        checkOutput({tag, ".exact"}, result,        expRes[0]);
        checkOutput({tag, ".mitch"}, result_approx, expRes[1]);
        checkOutput({tag, ".drum"},  result_drum,   expRes[2]);
        checkOutput({tag, ".foil"},  result_foil,   expRes[3]);
        checkOutput({tag, ".flags"}, {23'h0, obsFlags}, {23'h0, expFlags});
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".exact"}, result,        32'h0);
        checkOutput({tag, ".mitch"}, result_approx, 32'h0);
        checkOutput({tag, ".drum"},  result_drum,   32'h0);
        checkOutput({tag, ".foil"},  result_foil,   32'h0);
        checkOutput({tag, ".flags"}, {23'h0, obsFlags}, 32'h0);
    endtask

    function automatic logic [31:0] randomOperand();
        logic [7:0] e;
        case ($urandom_range(0, 3))
            0:       e = 8'($urandom_range(0, 255));
            1:       e = 8'($urandom_range(190, 255));
            2:       e = 8'($urandom_range(0, 64));
            default: e = 8'($urandom_range(96, 160));
        endcase
        return {1'($urandom), e, 23'($urandom)};
    endfunction

    initial begin
        rst       = 1'b1;
        a_operand = 32'h3FC0_0000;
        b_operand = 32'h4000_0000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;

        // 1.5 x 2
        applyStimulus(32'h3FC0_0000, 32'h4000_0000);
        checkOutput("1.5x2.exact", result,        32'h4040_0000);
        checkOutput("1.5x2.mitch", result_approx, 32'h4040_0000);
        checkOutput("1.5x2.foil",  result_foil,   32'h4040_0000);
        checkOutput("1.5x2.flags", {23'h0, obsFlags}, 32'h0);
        checkAgainstModel("1.5x2");

        // 1.5 x 1.5: Mitchell takes the 2(x+y) branch
        applyStimulus(32'h3FC0_0000, 32'h3FC0_0000);
        checkOutput("1.5x1.5.exact", result,        32'h4010_0000);
        checkOutput("1.5x1.5.mitch", result_approx, 32'h4000_0000);
        checkOutput("1.5x1.5.foil",  result_foil,   32'h4010_0000);
        checkAgainstModel("1.5x1.5");

        // 1 x 1: DRUM's forced LSB shows up in the mantissa
        applyStimulus(32'h3F80_0000, 32'h3F80_0000);
        checkOutput("1x1.exact", result,        32'h3F80_0000);
        checkOutput("1x1.mitch", result_approx, 32'h3F80_0000);
        checkOutput("1x1.drum",  result_drum,   32'h3F88_2000);
        checkOutput("1x1.foil",  result_foil,   32'h3F80_0000);
        checkAgainstModel("1x1");

        // Overflow on every path
        applyStimulus(32'h7F00_0000, 32'h4000_0000);
        checkOutput("ovf.exact", result,        32'h7F80_0000);
        checkOutput("ovf.mitch", result_approx, 32'h7F80_0000);
        checkOutput("ovf.drum",  result_drum,   32'h7F80_0000);
        checkOutput("ovf.foil",  result_foil,   32'h7F80_0000);
        checkOutput("ovf.flags", {23'h0, obsFlags}, {23'h0, 9'b0_10_10_10_10});

        // Underflow on every path (biased exponent lands exactly on 0)
        applyStimulus(32'h0080_0000, 32'h3F00_0000);
        checkOutput("unf.exact", result,        32'h0);
        checkOutput("unf.mitch", result_approx, 32'h0);
        checkOutput("unf.drum",  result_drum,   32'h0);
        checkOutput("unf.foil",  result_foil,   32'h0);
        checkOutput("unf.flags", {23'h0, obsFlags}, {23'h0, 9'b0_01_01_01_01});

        // Zero operand beats underflow
        applyStimulus(32'h0000_0000, 32'h4000_0000);
        checkOutput("zero.exact", result, 32'h0);
        checkOutput("zero.flags", {23'h0, obsFlags}, 32'h0);

        // Infinity operand
        applyStimulus(32'h7F80_0000, 32'h3F80_0000);
        checkOutput("exc.exact", result,        32'h7F80_0000);
        checkOutput("exc.mitch", result_approx, 32'h7F80_0000);
        checkOutput("exc.drum",  result_drum,   32'h7F80_0000);
        checkOutput("exc.foil",  result_foil,   32'h7F80_0000);
        checkOutput("exc.flags", {23'h0, obsFlags}, {23'h0, 9'b1_00_00_00_00});

        // Reset overrides an operand pair presented on the same edge
        rst = 1'b1;
        applyStimulus(32'hC000_0000, 32'h4040_0000);
        checkAllZero("rstOverride");
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("postReset.exact", result, 32'hC0C0_0000);
        checkAgainstModel("postReset");

        // Random operand pairs against the reference model
        for (int i = 0; i < 300; i++) begin
            applyStimulus(randomOperand(), randomOperand());
            checkAgainstModel("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
